// File: rtl/sram_mem_controller_pkg.sv
// ---------------------------------------------------------------------------
// sram_ctrl_pkg
// Shared definitions for the MEM-stage SRAM controller slice.
//   state_t            : controller FSM states IDLE -> ACCESS -> DONE
//   SRAM_DQ_W          : width of the external SRAM data bus
//   WORD_W / LINE_W    : CPU word width and one SRAM location (line) width
//   DEFAULT_*          : default parameter values for the controller
//   byte_to_word()     : byte address -> SRAM word index relative to a base
// ---------------------------------------------------------------------------
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam int SRAM_DQ_W           = 64;
   localparam int WORD_W              = 32;
   localparam int LINE_W              = 64;
   localparam int DEFAULT_ADDR_BASE   = 1024;
   localparam int DEFAULT_ADDR_W      = 17;
   localparam int DEFAULT_WAIT_CYCLES = 5;

   // The subtraction wraps modulo 2^32, so addresses below the base alias
   // onto the top of the SRAM instead of being rejected.
   function automatic logic [31:0] byte_to_word(input logic [31:0] byte_addr,
                                                input logic [31:0] base);
      return (byte_addr - base) >> 2;
   endfunction

endpackage

// File: rtl/sram_mem_controller_if.sv
// ---------------------------------------------------------------------------
// sram_mem_controller_if
// MEM-stage side of the SRAM controller.
//   mem_r_en / mem_w_en : load / store request levels (held while frozen)
//   mem_addr / mem_wdata: byte address and store data
//   mem_rdata           : load result, valid while ready is high
//   ready               : one-cycle completion pulse
//   freeze              : pipeline stall request
// Modports: master = MEM stage, slave = controller.
// ---------------------------------------------------------------------------
interface sram_mem_controller_if;
   import sram_ctrl_pkg::*;

   logic              mem_r_en;
   logic              mem_w_en;
   logic [WORD_W-1:0] mem_addr;
   logic [WORD_W-1:0] mem_wdata;
   logic [WORD_W-1:0] mem_rdata;
   logic              ready;
   logic              freeze;

   modport master (
      output mem_r_en, mem_w_en, mem_addr, mem_wdata,
      input  mem_rdata, ready, freeze
   );

   modport slave (
      input  mem_r_en, mem_w_en, mem_addr, mem_wdata,
      output mem_rdata, ready, freeze
   );

endinterface

// File: rtl/sram_mem_controller_line_buf.sv
// ---------------------------------------------------------------------------
// sram_line_buf
// Single-entry 64-bit line buffer in front of the SRAM. Only built when the
// SRAM_LINE_BUF_EN macro is defined.
//   clk, rst    : clock, asynchronous active-low reset (clears valid)
//   lookup_word : word index of the current request
//   hit / rdata : tag match and selected 32-bit half of the buffered line
//   fill_*      : load-miss refill with a full SRAM location
//   upd_*       : store write-through into the buffered line
// ---------------------------------------------------------------------------
`ifdef SRAM_LINE_BUF_EN
module sram_line_buf
   import sram_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lookup_word,
   output logic              hit,
   output logic [WORD_W-1:0] rdata,
   input  logic              fill_en,
   input  logic [ADDR_W-2:0] fill_tag,
   input  logic [LINE_W-1:0] fill_data,
   input  logic              upd_en,
   input  logic [ADDR_W-1:0] upd_word,
   input  logic [WORD_W-1:0] upd_data
);

   logic              valid;
   logic [ADDR_W-2:0] tag;
   logic [LINE_W-1:0] line;
   logic              upd_match;

   // The tag drops the half-select bit, so both 32-bit halves of a line
   // share one entry.
   assign hit       = valid && (tag == lookup_word[ADDR_W-1:1]);
   assign rdata     = lookup_word[0] ? line[63:32] : line[31:0];
   assign upd_match = valid && (tag == upd_word[ADDR_W-1:1]);

   // Refill replaces the whole entry; a store only patches its own half and
   // never allocates, so a store miss leaves the buffer untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid <= 1'b0;
         tag   <= '0;
         line  <= '0;
      end else if (fill_en) begin
         valid <= 1'b1;
         tag   <= fill_tag;
         line  <= fill_data;
      end else if (upd_en && upd_match) begin
         if (upd_word[0]) begin
            line[63:32] <= upd_data;
         end else begin
            line[31:0] <= upd_data;
         end
      end
   end

endmodule
`endif

// File: rtl/sram_mem_controller.sv
// ---------------------------------------------------------------------------
// sram_mem_controller
// Turns one 32-bit MEM-stage load/store into a multi-cycle transaction on a
// 64-bit external SRAM and freezes the pipeline while it runs.
//   clk, rst   : clock (rising edge), asynchronous active-low reset
//   bus        : MEM-stage request/response (sram_mem_controller_if.slave)
//   SRAM_ADDR  : registered SRAM word address
//   SRAM_DQ    : SRAM data, driven {32'b0, wdata} only while SRAM_WE_N = 0
//   SRAM_WE_N  : registered active-low write enable, low for one cycle/store
// Parameters: WAIT_CYCLES (ACCESS cycles, >= 1), ADDR_BASE, ADDR_W.
// Optional macro SRAM_LINE_BUF_EN adds a one-line read buffer so that loads
// hitting the buffered line complete in the request cycle without a stall.
// ---------------------------------------------------------------------------
module sram_mem_controller
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
   parameter int ADDR_BASE   = DEFAULT_ADDR_BASE,
   parameter int ADDR_W      = DEFAULT_ADDR_W
) (
   input  logic                 clk,
   input  logic                 rst,
   sram_mem_controller_if.slave bus,
   output logic [ADDR_W-1:0]    SRAM_ADDR,
   inout  wire  [SRAM_DQ_W-1:0] SRAM_DQ,
   output logic                 SRAM_WE_N
);

   localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  cnt;
   logic              op_store;
   logic              half_q;
   logic [WORD_W-1:0] wdata_q;
   logic [WORD_W-1:0] rdata_q;
   logic [31:0]       req_word_full;
   logic [ADDR_W-1:0] req_word;
   logic              req;
   logic              accept;
   logic              freeze_c;
   logic              ready_c;
   logic              hit_load;
   logic [WORD_W-1:0] hit_data;
   logic              last_access;
   logic [WORD_W-1:0] dq_half;
   logic              unused_word_bits;

   assign req           = bus.mem_r_en | bus.mem_w_en;
   assign req_word_full = byte_to_word(bus.mem_addr, 32'(ADDR_BASE));
   assign req_word      = req_word_full[ADDR_W-1:0];
   assign unused_word_bits = ^req_word_full[31:ADDR_W];
   assign last_access   = (state == ACCESS) && (cnt == '0);
   assign dq_half       = half_q ? SRAM_DQ[63:32] : SRAM_DQ[31:0];

`ifdef SRAM_LINE_BUF_EN
   logic              buf_hit;
   logic [WORD_W-1:0] buf_rdata;

   // Refill happens on the edge that enters DONE, using the same DQ value
   // the load result is taken from; stores patch the buffer as they start.
   sram_line_buf #(
      .ADDR_W (ADDR_W)
   ) u_line_buf (
      .clk         (clk),
      .rst         (rst),
      .lookup_word (req_word),
      .hit         (buf_hit),
      .rdata       (buf_rdata),
      .fill_en     (last_access && !op_store),
      .fill_tag    (SRAM_ADDR[ADDR_W-1:1]),
      .fill_data   (SRAM_DQ),
      .upd_en      (accept && bus.mem_w_en),
      .upd_word    (req_word),
      .upd_data    (bus.mem_wdata)
   );

   // A pure load (store has priority when both enables are high) that hits
   // the buffer is answered combinationally in IDLE.
   assign hit_load      = (state == IDLE) && bus.mem_r_en && !bus.mem_w_en && buf_hit;
   assign hit_data      = buf_rdata;
   assign bus.mem_rdata = hit_load ? buf_rdata : rdata_q;
`else
   assign hit_load      = 1'b0;
   assign hit_data      = '0;
   assign bus.mem_rdata = rdata_q;
`endif

   // The controller only drives the data pins during the single write cycle.
   assign SRAM_DQ = SRAM_WE_N ? {SRAM_DQ_W{1'bz}}
                              : {{(SRAM_DQ_W-WORD_W){1'b0}}, wdata_q};

   // State register; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and handshake. Requests are only looked at in IDLE, so an
   // enable that drops mid-transaction still sees its ready pulse, and a
   // request held through DONE is picked up again in the following IDLE.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      freeze_c   = 1'b0;
      ready_c    = 1'b0;
      case (state)
         IDLE: begin
            if (hit_load) begin
               ready_c = 1'b1;
            end else if (req) begin
               freeze_c   = 1'b1;
               accept     = 1'b1;
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            freeze_c = 1'b1;
            if (cnt == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            ready_c    = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Gated with reset so a request held during reset does not stall.
   assign bus.freeze = rst & freeze_c;
   assign bus.ready  = rst & ready_c;

   // Transaction datapath. The request is latched on the IDLE->ACCESS edge,
   // which also starts the single write-enable cycle for stores. The load
   // result is selected from DQ on the edge that leaves the last ACCESS
   // cycle and then holds until the next load completes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         op_store  <= 1'b0;
         half_q    <= 1'b0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         SRAM_ADDR <= '0;
         SRAM_WE_N <= 1'b1;
      end else begin
         if (accept) begin
            cnt       <= CNT_W'(WAIT_CYCLES - 1);
            op_store  <= bus.mem_w_en;
            half_q    <= req_word[0];
            wdata_q   <= bus.mem_wdata;
            SRAM_ADDR <= req_word;
            SRAM_WE_N <= ~bus.mem_w_en;
         end else if (hit_load) begin
            rdata_q <= hit_data;
         end else if (state == ACCESS) begin
            SRAM_WE_N <= 1'b1;
            if (cnt != '0) begin
               cnt <= cnt - 1'b1;
            end else if (!op_store) begin
               rdata_q <= dq_half;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_controller
// Bench for sram_mem_controller: one instance with the default timing and one
// with WAIT_CYCLES = 1, each attached to a small behavioural 64-bit SRAM.
// Load results are predicted into a scoreboard queue when the load is issued
// and compared when ready pulses.
// ---------------------------------------------------------------------------
module tb_sram_mem_controller;

   typedef struct {
      logic        is_load;
      logic        is_store;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [16:0] exp_sram_addr;
      int          exp_we_low;
   } vec_t;

   logic clk = 1'b0;
   logic rst;

   sram_mem_controller_if bus0 ();
   sram_mem_controller_if bus1 ();

   logic [16:0] addr0;
   logic [16:0] addr1;
   logic        we_n0;
   logic        we_n1;
   wire  [63:0] dq0;
   wire  [63:0] dq1;

   logic [63:0] mem0 [0:15];
   logic [63:0] mem1 [0:15];

   logic        pre_en = 1'b0;
   logic        pre_sel = 1'b0;
   logic [3:0]  pre_idx = '0;
   logic [63:0] pre_data = '0;

   logic [31:0] sb0 [$];
   logic [31:0] sb1 [$];

   int total = 0;
   int bad   = 0;

   logic unused_tb;
   assign unused_tb = ^{addr0[16:4], addr1[16:4]};

   sram_mem_controller #(
      .WAIT_CYCLES (5),
      .ADDR_BASE   (1024),
      .ADDR_W      (17)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus0),
      .SRAM_ADDR (addr0),
      .SRAM_DQ   (dq0),
      .SRAM_WE_N (we_n0)
   );

   sram_mem_controller #(
      .WAIT_CYCLES (1),
      .ADDR_BASE   (1024),
      .ADDR_W      (17)
   ) dut1 (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus1),
      .SRAM_ADDR (addr1),
      .SRAM_DQ   (dq1),
      .SRAM_WE_N (we_n1)
   );

   always #5 clk = ~clk;

   // Behavioural SRAMs: drive DQ whenever not being written, write on the
   // rising edge while WE_N is low. Backdoor preloads share this process.
   assign dq0 = we_n0 ? mem0[addr0[3:0]] : 64'bz;
   assign dq1 = we_n1 ? mem1[addr1[3:0]] : 64'bz;

   always @(posedge clk) begin
      if (!we_n0) begin
         mem0[addr0[3:0]] <= dq0;
      end else if (pre_en && !pre_sel) begin
         mem0[pre_idx] <= pre_data;
      end
      if (!we_n1) begin
         mem1[addr1[3:0]] <= dq1;
      end else if (pre_en && pre_sel) begin
         mem1[pre_idx] <= pre_data;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=running required=finished");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
      end
   endtask

   task automatic pop_compare(input logic which, input logic [31:0] actual);
      logic [31:0] e;
      if ((which ? sb1.size() : sb0.size()) == 0) begin
         total++;
         bad++;
         $display("[TB] FAIL scoreboard actual=ready_without_load required=pending_load");
      end else begin
         e = which ? sb1.pop_front() : sb0.pop_front();
         check_output("load_rdata", 64'(actual), 64'(e));
      end
   endtask

   task automatic preload(input logic which, input logic [3:0] idx, input logic [63:0] data);
      @(negedge clk);
      pre_sel  = which;
      pre_idx  = idx;
      pre_data = data;
      pre_en   = 1'b1;
      @(negedge clk);
      pre_en   = 1'b0;
   endtask

   // One transaction on the default instance; request held until ready.
   task automatic apply_stimulus(input logic is_load, input logic is_store,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] exp_rdata,
                                 output int stall, output int we_low,
                                 output logic [16:0] we_addr, output logic got_ready,
                                 output logic [16:0] done_addr);
      @(negedge clk);
      bus0.mem_r_en  = is_load;
      bus0.mem_w_en  = is_store;
      bus0.mem_addr  = addr;
      bus0.mem_wdata = wdata;
      if (is_load && !is_store) sb0.push_back(exp_rdata);
      stall     = 0;
      we_low    = 0;
      we_addr   = '0;
      got_ready = 1'b0;
      done_addr = '0;
      #1;
      for (int k = 0; k < 40; k++) begin
         if (bus0.freeze) stall++;
         if (!we_n0) begin
            we_low++;
            we_addr = addr0;
         end
         if (bus0.ready) begin
            got_ready = 1'b1;
            done_addr = addr0;
            if (is_load && !is_store) pop_compare(1'b0, bus0.mem_rdata);
            break;
         end
         @(negedge clk);
         #1;
      end
      bus0.mem_r_en = 1'b0;
      bus0.mem_w_en = 1'b0;
   endtask

   initial begin
      vec_t        vecs [9];
      int          stall;
      int          we_low;
      logic [16:0] we_addr;
      logic [16:0] done_addr;
      logic        got_ready;
      int          cyc;
      int          freeze_cnt;
      int          ready_cnt;

      vecs[0] = '{1'b0, 1'b1, 32'h0000_0408, 32'hDEAD_BEEF, 32'h0, 17'd2, 1};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_0408, 32'h0, 32'hDEAD_BEEF, 17'd2, 0};
      vecs[2] = '{1'b0, 1'b1, 32'h0000_0400, 32'h0000_0011, 32'h0, 17'd0, 1};
      vecs[3] = '{1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0000_0011, 17'd0, 0};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_040C, 32'h0, 32'h1234_5678, 17'd3, 0};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'h0000_0022, 17'd1, 0};
      vecs[6] = '{1'b1, 1'b1, 32'h0000_0410, 32'h0000_0005, 32'h0, 17'd4, 1};
      vecs[7] = '{1'b1, 1'b0, 32'h0000_0410, 32'h0, 32'h0000_0005, 17'd4, 0};
      vecs[8] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0, 32'hA5A5_A5A5, 17'h1FFFF, 0};

      rst = 1'b0;
      bus0.mem_r_en = 1'b0; bus0.mem_w_en = 1'b0; bus0.mem_addr = '0; bus0.mem_wdata = '0;
      bus1.mem_r_en = 1'b0; bus1.mem_w_en = 1'b0; bus1.mem_addr = '0; bus1.mem_wdata = '0;

      // Reset values.
      repeat (2) @(negedge clk);
      #1;
      check_output("rst_freeze", 64'(bus0.freeze), 64'd0);
      check_output("rst_ready", 64'(bus0.ready), 64'd0);
      check_output("rst_we_n", 64'(we_n0), 64'd1);
      check_output("rst_sram_addr", 64'(addr0), 64'd0);
      check_output("rst_rdata", 64'(bus0.mem_rdata), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Reset in the middle of a store's ACCESS phase.
      @(negedge clk);
      bus0.mem_w_en  = 1'b1;
      bus0.mem_addr  = 32'h0000_0408;
      bus0.mem_wdata = 32'hCAFE_F00D;
      repeat (3) @(negedge clk);
      #1;
      check_output("mid_freeze", 64'(bus0.freeze), 64'd1);
      rst = 1'b0;
      #1;
      check_output("mid_rst_freeze", 64'(bus0.freeze), 64'd0);
      check_output("mid_rst_ready", 64'(bus0.ready), 64'd0);
      check_output("mid_rst_we_n", 64'(we_n0), 64'd1);
      check_output("mid_rst_sram_addr", 64'(addr0), 64'd0);
      bus0.mem_w_en = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      check_output("post_rst_freeze", 64'(bus0.freeze), 64'd0);
      check_output("post_rst_ready", 64'(bus0.ready), 64'd0);
      check_output("post_rst_we_n", 64'(we_n0), 64'd1);

      // Backdoor contents for upper-half and wrap-around reads.
      preload(1'b0, 4'd1, {32'h0000_0022, 32'h5555_5555});
      preload(1'b0, 4'd3, {32'h1234_5678, 32'h9ABC_DEF0});
      preload(1'b0, 4'd15, {32'hA5A5_A5A5, 32'h0000_0000});

      for (int i = 0; i < 9; i++) begin
         apply_stimulus(vecs[i].is_load, vecs[i].is_store, vecs[i].addr, vecs[i].wdata,
                        vecs[i].exp_rdata, stall, we_low, we_addr, got_ready, done_addr);
         check_output("vec_ready", 64'(got_ready), 64'd1);
         check_output("vec_stall", 64'(stall), 64'd6);
         check_output("vec_we_low", 64'(we_low), 64'(vecs[i].exp_we_low));
         check_output("vec_sram_addr", 64'(done_addr), 64'(vecs[i].exp_sram_addr));
         if (vecs[i].exp_we_low != 0) begin
            check_output("vec_we_addr", 64'(we_addr), 64'(vecs[i].exp_sram_addr));
         end
      end

      // Load whose enable drops after the first cycle still completes.
      @(negedge clk);
      bus0.mem_r_en = 1'b1;
      bus0.mem_addr = 32'h0000_0408;
      sb0.push_back(32'hDEAD_BEEF);
      @(negedge clk);
      bus0.mem_r_en = 1'b0;
      cyc = 0;
      for (int k = 1; k < 20; k++) begin
         #1;
         if (bus0.ready) begin
            cyc = k;
            pop_compare(1'b0, bus0.mem_rdata);
            break;
         end
         @(negedge clk);
      end
      check_output("drop_ready_cycle", 64'(cyc), 64'd6);
      @(negedge clk);
      #1;
      check_output("drop_after_ready", 64'(bus0.ready), 64'd0);
      check_output("drop_after_freeze", 64'(bus0.freeze), 64'd0);
      check_output("rdata_hold", 64'(bus0.mem_rdata), 64'hDEAD_BEEF);

      // WAIT_CYCLES = 1: two loads back to back with the enable held high.
      preload(1'b1, 4'd0, {32'h0000_0000, 32'h0000_AAAA});
      preload(1'b1, 4'd3, {32'h0000_BBBB, 32'h0000_0000});
      @(negedge clk);
      bus1.mem_r_en = 1'b1;
      bus1.mem_addr = 32'h0000_0400;
      sb1.push_back(32'h0000_AAAA);
      freeze_cnt = 0;
      ready_cnt  = 0;
      cyc        = -1;
      #1;
      for (int k = 0; k < 20; k++) begin
         if (bus1.freeze) freeze_cnt++;
         if (bus1.ready) begin
            ready_cnt++;
            pop_compare(1'b1, bus1.mem_rdata);
            if (ready_cnt == 1) begin
               bus1.mem_addr = 32'h0000_040C;
               sb1.push_back(32'h0000_BBBB);
            end else begin
               bus1.mem_r_en = 1'b0;
               cyc = k;
               break;
            end
         end
         @(negedge clk);
         #1;
      end
      check_output("w1_freeze_cycles", 64'(freeze_cnt), 64'd4);
      check_output("w1_ready_count", 64'(ready_cnt), 64'd2);
      check_output("w1_last_ready_cycle", 64'(cyc), 64'd5);
      @(negedge clk);
      #1;
      check_output("w1_idle_ready", 64'(bus1.ready), 64'd0);
      check_output("w1_idle_freeze", 64'(bus1.freeze), 64'd0);

`ifdef SRAM_LINE_BUF_EN
      // Line buffer: miss fills, the other half then hits without a stall,
      // and a store writes through into the buffered half.
      preload(1'b0, 4'd0, {32'h4444_0404, 32'h0000_0011});
      apply_stimulus(1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h0000_0011,
                     stall, we_low, we_addr, got_ready, done_addr);
      check_output("buf_miss_stall", 64'(stall), 64'd6);
      apply_stimulus(1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'h4444_0404,
                     stall, we_low, we_addr, got_ready, done_addr);
      check_output("buf_hit_ready", 64'(got_ready), 64'd1);
      check_output("buf_hit_stall", 64'(stall), 64'd0);
      apply_stimulus(1'b0, 1'b1, 32'h0000_0404, 32'h0000_0077, 32'h0,
                     stall, we_low, we_addr, got_ready, done_addr);
      check_output("buf_store_stall", 64'(stall), 64'd6);
      check_output("buf_store_we_low", 64'(we_low), 64'd1);
      apply_stimulus(1'b1, 1'b0, 32'h0000_0404, 32'h0, 32'h0000_0077,
                     stall, we_low, we_addr, got_ready, done_addr);
      check_output("buf_hit2_stall", 64'(stall), 64'd0);
      check_output("buf_hit2_we_low", 64'(we_low), 64'd0);
`endif

      check_output("sb0_drained", 64'(sb0.size()), 64'd0);
      check_output("sb1_drained", 64'(sb1.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
